hex_rx_parser: RTL and testbench
================================

Name: hex_rx_parser

Overview:
- Sits between the UART receiver (rxuartlite) and the INBOX FIFO (ufifo).
- Consumes raw received ASCII bytes, turns pairs of hex digits into binary bytes and pushes them into the FIFO. Users can type values such as "3F 0a 7" on a terminal.
- Also decodes a single-character FIFO-clear command.
- Keeps saturating error and overflow counters for display by a downstream vgaWord label.

Parameters:
- CNT_W, 8, width of the error and drop counters (saturating).
- SEP_SINGLE, 1, 1 = a separator after a lone digit emits byte 0x0N; 0 = the lone digit is discarded and counted as an error.

Ports:
- clk  input  1  system clock (12 MHz), the same domain as rxuartlite and the INBOX.
- reset_n  input  1  synchronous active-low reset.
- i_wr  input  1  one-cycle strobe: i_data holds a received byte.
- i_data  input  8  received ASCII byte.
- i_full  input  1  FIFO full flag (INBOX o_full).
- o_wr  output  1  one-cycle FIFO push strobe.
- o_data  output  8  parsed byte, valid while o_wr=1.
- o_fifo_rst  output  1  one-cycle FIFO clear pulse.
- o_pending  output  1  high while a high nibble is held.
- o_err_cnt  output  CNT_W  count of invalid characters.
- o_drop_cnt  output  CNT_W  count of bytes dropped because the FIFO was full.

Behaviour:
- Reset: all of these are 0: o_wr, o_data, o_fifo_rst, o_pending, o_err_cnt, o_drop_cnt and the held nibble. State returns to EMPTY.
- Reset takes priority over a simultaneous i_wr. A byte arriving in a reset cycle is lost.
- Character classes:
  - DIGIT: '0'-'9', 'A'-'F', 'a'-'f'. Value is 0-15.
  - SEP: 0x20, 0x0D, 0x0A, 0x2C (',').
  - CMD: 'R' (0x52) or 'r' (0x72).
  - Everything else is INVALID.
- FSM has two states: EMPTY and HIGH. HIGH holds nibble h. Only cycles with i_wr=1 change state.
- Transitions from EMPTY:
  - DIGIT d: h<=d, go to HIGH.
  - SEP: stay in EMPTY, no output.
  - CMD: pulse o_fifo_rst.
  - INVALID: err_cnt++, stay in EMPTY.
- Transitions from HIGH:
  - DIGIT d: emit {h,d}, go to EMPTY.
  - SEP: if SEP_SINGLE=1, emit {4'h0,h}; if SEP_SINGLE=0, err_cnt++. Go to EMPTY either way.
  - CMD: pulse o_fifo_rst, discard h, go to EMPTY.
  - INVALID: err_cnt++, discard h, go to EMPTY.
- Emit rule:
  - Latency: o_wr and o_data are registered, so o_wr=1 exactly one cycle after the i_wr that completes the byte.
  - i_full is sampled in the same cycle as that i_wr.
  - If i_full=1: o_wr stays 0, o_data is not updated, drop_cnt++.
- o_wr and o_fifo_rst are never high in the same cycle.
- o_data holds its last value when o_wr=0.
- Counters saturate at 2^CNT_W-1; they never wrap. Only reset clears them; o_fifo_rst does not.
- o_pending = (state==HIGH), registered.
- Back-to-back i_wr on consecutive cycles must be handled. Each i_wr is processed independently, with no bubble required.
- i_data is ignored when i_wr=0.

Decomposition:
- Shared package/header (next to const.vh):
  - ASCII constants: ASC_SP, ASC_CR, ASC_LF, ASC_COMMA, ASC_R_UP, ASC_R_LO.
  - State encodings ST_EMPTY, ST_HIGH.
- One natural sub-module, hex_digit_decode: combinational, i_chr[7:0] -> o_val[3:0], o_is_digit, o_is_sep, o_is_cmd. It is the inverse of hex2asc and reusable elsewhere.
- The parent holds the FSM, output registers and saturating counters.

Test Plan:
- After reset, send "3F": o_wr pulses once, 1 cycle after the 'F' strobe, with o_data=0x3F. o_pending is 1 between the two strobes.
- Send "a", space, "7", "c", LF: o_wr pulses twice, with 0x0A then 0x7C. err_cnt=0. Repeat with SEP_SINGLE=0: one push (0x7C) and err_cnt=1.
- Send "4", "G", "5", "5": 'G' raises err_cnt to 1 and clears pending. Exactly one push follows, 0x55.
- Hold i_full=1 and send "11 22": no o_wr, drop_cnt=2. Release i_full, send "33": a push of 0x33, drop_cnt stays 2.
- Send "9", then "r": o_fifo_rst pulses once, 1 cycle after the 'r' strobe, with no o_wr. o_pending=0. Counters are unchanged.
- Apply 300 invalid bytes ('Z') with CNT_W=8: err_cnt saturates at 255. Assert reset_n=0 for one cycle, coinciding with an i_wr of 'A': all outputs 0, o_pending=0.

Source files
------------

// File: rtl/hex_rx_parser_pkg.sv
// Shared definitions for the hex receive parser.
// Holds the ASCII codes the parser reacts to and the FSM state encoding.
// No ports; imported by the interface-using modules of this block.
package hex_rx_parser_pkg;

  // ASCII codes of separators and the FIFO-clear command
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_R_UP  = 8'h52;
  localparam logic [7:0] ASC_R_LO  = 8'h72;

  // Parser state: EMPTY = no nibble held, HIGH = high nibble held
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HIGH  = 1'b1
  } state_t;

endpackage

// File: rtl/hex_rx_parser_if.sv
// Byte stream bundle between the UART receiver, the parser and the INBOX FIFO.
// Signals:
//   i_wr, i_data   received-byte strobe and ASCII byte (UART -> parser)
//   i_full         FIFO full flag (FIFO -> parser)
//   o_wr, o_data   FIFO push strobe and parsed byte (parser -> FIFO)
//   o_fifo_rst     one-cycle FIFO clear pulse (parser -> FIFO)
// Modports: slave = parser side, master = environment side.
interface hex_rx_parser_if;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_full;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_fifo_rst;

  modport slave (
    input  i_wr, i_data, i_full,
    output o_wr, o_data, o_fifo_rst
  );

  modport master (
    output i_wr, i_data, i_full,
    input  o_wr, o_data, o_fifo_rst
  );
endinterface

// File: rtl/hex_rx_parser_hex_digit_decode.sv
// Combinational ASCII character classifier; inverse of hex2asc.
// Ports:
//   i_chr       ASCII character
//   o_val       nibble value 0-15 (0 when not a digit)
//   o_is_digit  '0'-'9', 'A'-'F', 'a'-'f'
//   o_is_sep    space, CR, LF or comma
//   o_is_cmd    'R' or 'r'
module hex_digit_decode
  import hex_rx_parser_pkg::*;
(
  input  logic [7:0] i_chr,
  output logic [3:0] o_val,
  output logic       o_is_digit,
  output logic       o_is_sep,
  output logic       o_is_cmd
);

  // Classify the character and derive its nibble value
  always_comb begin
    o_val      = 4'h0;
    o_is_digit = 1'b0;
    o_is_sep   = 1'b0;
    o_is_cmd   = 1'b0;
    if ((i_chr >= 8'h30) && (i_chr <= 8'h39)) begin
      o_is_digit = 1'b1;
      o_val      = i_chr[3:0];
    end else if (((i_chr >= 8'h41) && (i_chr <= 8'h46)) ||
                 ((i_chr >= 8'h61) && (i_chr <= 8'h66))) begin
      // Letters A-F / a-f have low nibble 1-6; adding 9 gives 10-15
      o_is_digit = 1'b1;
      o_val      = i_chr[3:0] + 4'd9;
    end else if ((i_chr == ASC_SP) || (i_chr == ASC_CR) ||
                 (i_chr == ASC_LF) || (i_chr == ASC_COMMA)) begin
      o_is_sep = 1'b1;
    end else if ((i_chr == ASC_R_UP) || (i_chr == ASC_R_LO)) begin
      o_is_cmd = 1'b1;
    end else begin
      o_val = 4'h0;
    end
  end

endmodule

// File: rtl/hex_rx_parser.sv
// Hex receive parser: turns pairs of ASCII hex digits into bytes pushed into
// the INBOX FIFO, decodes the 'R'/'r' FIFO-clear command and keeps saturating
// error and drop counters.
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   bus         byte stream bundle (slave side): i_wr/i_data/i_full in,
//               o_wr/o_data/o_fifo_rst out (all outputs registered)
//   o_pending   high while a high nibble is held
//   o_err_cnt   saturating count of invalid characters / lone digits
//   o_drop_cnt  saturating count of bytes lost to a full FIFO
module hex_rx_parser
  import hex_rx_parser_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter bit SEP_SINGLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  hex_rx_parser_if.slave   bus,
  output logic             o_pending,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       w_val;
  logic             w_is_digit;
  logic             w_is_sep;
  logic             w_is_cmd;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_nib;
  logic [3:0]       w_next_nib;
  logic             w_emit;
  logic [7:0]       w_emit_data;
  logic             w_clr;
  logic             w_err;

  logic             r_wr;
  logic [7:0]       r_data;
  logic             r_fifo_rst;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  hex_digit_decode u_dec (
    .i_chr      (bus.i_data),
    .o_val      (w_val),
    .o_is_digit (w_is_digit),
    .o_is_sep   (w_is_sep),
    .o_is_cmd   (w_is_cmd)
  );

  // Next-state and per-character actions; only strobed bytes are looked at
  always_comb begin
    w_next_state = r_state;
    w_next_nib   = r_nib;
    w_emit       = 1'b0;
    w_emit_data  = 8'h00;
    w_clr        = 1'b0;
    w_err        = 1'b0;
    if (bus.i_wr) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_is_digit) begin
            w_next_state = ST_HIGH;
            w_next_nib   = w_val;
          end else if (w_is_sep) begin
            w_next_state = ST_EMPTY;
          end else if (w_is_cmd) begin
            w_clr = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_HIGH: begin
          // Every character from HIGH consumes the held nibble
          w_next_state = ST_EMPTY;
          w_next_nib   = 4'h0;
          if (w_is_digit) begin
            w_emit      = 1'b1;
            w_emit_data = {r_nib, w_val};
          end else if (w_is_sep) begin
            if (SEP_SINGLE) begin
              w_emit      = 1'b1;
              w_emit_data = {4'h0, r_nib};
            end else begin
              w_err = 1'b1;
            end
          end else if (w_is_cmd) begin
            w_clr = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
          w_next_nib   = 4'h0;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // State, held nibble, output registers and saturating counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_nib      <= 4'h0;
      r_wr       <= 1'b0;
      r_data     <= 8'h00;
      r_fifo_rst <= 1'b0;
      r_err_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_nib      <= w_next_nib;
      r_wr       <= w_emit & ~bus.i_full;
      r_fifo_rst <= w_clr;
      if (w_emit && !bus.i_full) begin
        r_data <= w_emit_data;
      end
      if (w_emit && bus.i_full && (r_drop_cnt != CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      if (w_err && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_wr       = r_wr;
  assign bus.o_data     = r_data;
  assign bus.o_fifo_rst = r_fifo_rst;
  assign o_pending      = (r_state == ST_HIGH);
  assign o_err_cnt      = r_err_cnt;
  assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_hex_rx_parser.sv
// Directed bench for hex_rx_parser: a cycle table for the SEP_SINGLE=1
// instance, plus hand-written sequences for SEP_SINGLE=0, counter
// saturation and reset-over-strobe.
module tb_hex_rx_parser;

  logic       clk;
  logic       reset_n;
  logic       pend_a;
  logic [7:0] err_a;
  logic [7:0] drop_a;
  logic       pend_b;
  logic [7:0] err_b;
  logic [7:0] drop_b;

  int n_vec;
  int n_err;

  hex_rx_parser_if ifa ();
  hex_rx_parser_if ifb ();

  hex_rx_parser #(.CNT_W(8), .SEP_SINGLE(1'b1)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (ifa),
    .o_pending  (pend_a),
    .o_err_cnt  (err_a),
    .o_drop_cnt (drop_a)
  );

  hex_rx_parser #(.CNT_W(8), .SEP_SINGLE(1'b0)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (ifb),
    .o_pending  (pend_b),
    .o_err_cnt  (err_b),
    .o_drop_cnt (drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic       wr;
    logic [7:0] data;
    logic       full;
    logic       e_wr;
    logic [7:0] e_data;
    logic       e_rst;
    logic       e_pend;
    logic [7:0] e_err;
    logic [7:0] e_drop;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rstn, input logic wr, input logic [7:0] data,
                              input logic full, input logic e_wr, input logic [7:0] e_data,
                              input logic e_rst, input logic e_pend, input logic [7:0] e_err,
                              input logic [7:0] e_drop);
    vec_t v;
    v.rstn = rstn; v.wr = wr; v.data = data; v.full = full;
    v.e_wr = e_wr; v.e_data = e_data; v.e_rst = e_rst; v.e_pend = e_pend;
    v.e_err = e_err; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %02h expected %02h", nm, idx, act, exp);
    end
  endtask

  logic [7:0] seq_b [5];
  int         pushes_b;
  logic [7:0] last_b;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    ifa.i_wr = 1'b0; ifa.i_data = 8'h00; ifa.i_full = 1'b0;
    ifb.i_wr = 1'b0; ifb.i_data = 8'h00; ifb.i_full = 1'b0;

    //              rstn wr   data   full ewr  edata  erst pend err    drop
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[1]  = mk(1'b1, 1'b1, "3",   1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 8'd0);
    vecs[2]  = mk(1'b1, 1'b1, "F",   1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[4]  = mk(1'b1, 1'b1, "a",   1'b0, 1'b0, 8'h3F, 1'b0, 1'b1, 8'd0, 8'd0);
    vecs[5]  = mk(1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[6]  = mk(1'b1, 1'b1, "7",   1'b0, 1'b0, 8'h0A, 1'b0, 1'b1, 8'd0, 8'd0);
    vecs[7]  = mk(1'b1, 1'b1, "c",   1'b0, 1'b1, 8'h7C, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[8]  = mk(1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 8'h7C, 1'b0, 1'b0, 8'd0, 8'd0);
    vecs[9]  = mk(1'b1, 1'b1, "4",   1'b0, 1'b0, 8'h7C, 1'b0, 1'b1, 8'd0, 8'd0);
    vecs[10] = mk(1'b1, 1'b1, "G",   1'b0, 1'b0, 8'h7C, 1'b0, 1'b0, 8'd1, 8'd0);
    vecs[11] = mk(1'b1, 1'b1, "5",   1'b0, 1'b0, 8'h7C, 1'b0, 1'b1, 8'd1, 8'd0);
    vecs[12] = mk(1'b1, 1'b1, "5",   1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'd1, 8'd0);
    vecs[13] = mk(1'b1, 1'b1, "1",   1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'd1, 8'd0);
    vecs[14] = mk(1'b1, 1'b1, "1",   1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'd1, 8'd1);
    vecs[15] = mk(1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'd1, 8'd1);
    vecs[16] = mk(1'b1, 1'b1, "2",   1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'd1, 8'd1);
    vecs[17] = mk(1'b1, 1'b1, "2",   1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[18] = mk(1'b1, 1'b1, "3",   1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 8'd1, 8'd2);
    vecs[19] = mk(1'b1, 1'b1, "3",   1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[20] = mk(1'b1, 1'b1, "9",   1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'd1, 8'd2);
    vecs[21] = mk(1'b1, 1'b1, "r",   1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'd1, 8'd2);
    vecs[22] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[23] = mk(1'b1, 1'b1, "R",   1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 8'd1, 8'd2);
    vecs[24] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[25] = mk(1'b1, 1'b1, "5",   1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 8'd1, 8'd2);
    vecs[26] = mk(1'b1, 1'b1, 8'h2C, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[27] = mk(1'b1, 1'b1, "e",   1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 8'd1, 8'd2);
    vecs[28] = mk(1'b1, 1'b1, 8'h0D, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b0, 8'd1, 8'd2);
    vecs[29] = mk(1'b1, 1'b0, "Z",   1'b0, 1'b0, 8'h0E, 1'b0, 1'b0, 8'd1, 8'd2);

    // Table: inputs applied away from the rising edge, outputs checked one cycle later
    for (int i = 0; i < NV; i++) begin
      reset_n    = vecs[i].rstn;
      ifa.i_wr   = vecs[i].wr;
      ifa.i_data = vecs[i].data;
      ifa.i_full = vecs[i].full;
      @(negedge clk);
      chk("o_wr",       i, {7'd0, ifa.o_wr},       {7'd0, vecs[i].e_wr});
      chk("o_data",     i, ifa.o_data,             vecs[i].e_data);
      chk("o_fifo_rst", i, {7'd0, ifa.o_fifo_rst}, {7'd0, vecs[i].e_rst});
      chk("o_pending",  i, {7'd0, pend_a},         {7'd0, vecs[i].e_pend});
      chk("o_err_cnt",  i, err_a,                  vecs[i].e_err);
      chk("o_drop_cnt", i, drop_a,                 vecs[i].e_drop);
    end
    ifa.i_wr = 1'b0;

    // SEP_SINGLE=0: lone digit before a separator is an error, not a push
    seq_b[0] = "a"; seq_b[1] = 8'h20; seq_b[2] = "7"; seq_b[3] = "c"; seq_b[4] = 8'h0A;
    pushes_b = 0;
    last_b   = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ifb.i_wr   = (i < 5);
      ifb.i_data = (i < 5) ? seq_b[i] : 8'h00;
      @(negedge clk);
      if (ifb.o_wr) begin
        pushes_b++;
        last_b = ifb.o_data;
      end
    end
    ifb.i_wr = 1'b0;
    chk("b_pushes",   0, 8'(pushes_b), 8'd1);
    chk("b_data",     0, last_b,       8'h7C);
    chk("b_err_cnt",  0, err_b,        8'd1);
    chk("b_pending",  0, {7'd0, pend_b}, 8'd0);
    chk("b_drop_cnt", 0, drop_b,       8'd0);

    // Error counter saturation with back-to-back invalid bytes
    ifa.i_data = "Z";
    for (int i = 0; i < 300; i++) begin
      ifa.i_wr = 1'b1;
      @(negedge clk);
      if (i == 252) chk("err_sat_254", i, err_a, 8'd254);
      if (i == 253) chk("err_sat_255", i, err_a, 8'd255);
    end
    ifa.i_wr = 1'b0;
    chk("err_sat_end", 0, err_a,  8'd255);
    chk("drop_hold",   0, drop_a, 8'd2);
    chk("sat_no_wr",   0, {7'd0, ifa.o_wr}, 8'd0);

    // Reset coinciding with a strobed 'A'
    reset_n    = 1'b0;
    ifa.i_wr   = 1'b1;
    ifa.i_data = "A";
    @(negedge clk);
    chk("rst_wr",   0, {7'd0, ifa.o_wr},       8'd0);
    chk("rst_data", 0, ifa.o_data,             8'h00);
    chk("rst_frst", 0, {7'd0, ifa.o_fifo_rst}, 8'd0);
    chk("rst_pend", 0, {7'd0, pend_a},         8'd0);
    chk("rst_err",  0, err_a,                  8'd0);
    chk("rst_drop", 0, drop_a,                 8'd0);
    reset_n  = 1'b1;
    ifa.i_wr = 1'b0;
    @(negedge clk);
    chk("post_rst_pend", 0, {7'd0, pend_a},    8'd0);
    chk("post_rst_wr",   0, {7'd0, ifa.o_wr},  8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
